// File: rtl/freq_calc_if.sv
// freq_calc_if: bundles the measurement-in, result-out and status signals of freq_calc.
//   meas_wr_en_i    measurement-done pulse (one cycle)
//   meas_wr_data_i  [31:0] sig_cnt, [63:32] clk_cnt, [95:64] ignored
//   freq_valid_o    result valid, held until accepted
//   freq_ready_i    consumer accepts when high together with valid
//   freq_data_o     frequency in Hz (truncated, saturated on ovf/div0)
//   freq_ovf_o      quotient did not fit in 32 bits
//   freq_div0_o     clk_cnt was zero
//   busy_o          block is not idle
//   drop_cnt_o      saturating count of discarded measurement pulses
// Modport master is the producer/consumer side, slave is the calculator.
interface freq_calc_if;
    logic        meas_wr_en_i;
    logic [95:0] meas_wr_data_i;
    logic        freq_valid_o;
    logic        freq_ready_i;
    logic [31:0] freq_data_o;
    logic        freq_ovf_o;
    logic        freq_div0_o;
    logic        busy_o;
    logic [15:0] drop_cnt_o;

    modport master (
        output meas_wr_en_i,
        output meas_wr_data_i,
        output freq_ready_i,
        input  freq_valid_o,
        input  freq_data_o,
        input  freq_ovf_o,
        input  freq_div0_o,
        input  busy_o,
        input  drop_cnt_o
    );

    modport slave (
        input  meas_wr_en_i,
        input  meas_wr_data_i,
        input  freq_ready_i,
        output freq_valid_o,
        output freq_data_o,
        output freq_ovf_o,
        output freq_div0_o,
        output busy_o,
        output drop_cnt_o
    );
endinterface

// File: rtl/freq_calc.sv
// freq_calc: computes f_sig = sig_cnt * CLK_FREQ / clk_cnt in integer Hz from each measurement
// pulse, using one multiply cycle and a 64-iteration restoring divider.
//   clk_i    reference clock, rising edge
//   rst_n_i  synchronous active-low reset
//   bus      freq_calc_if.slave (measurement input, valid/ready result, status)
module freq_calc #(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input logic        clk_i,
    input logic        rst_n_i,
    freq_calc_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StOut} state_e;

    state_e      state_q;
    logic [31:0] sig_cnt_q;
    logic [31:0] clk_cnt_q;
    logic [63:0] num_q;
    logic [31:0] rem_q;
    logic [63:0] quo_q;
    logic [6:0]  iter_q;
    logic        valid_q;
    logic [31:0] data_q;
    logic        ovf_q;
    logic        div0_q;
    logic        busy_q;
    logic [15:0] drop_cnt_q;

    // One restoring-division step. The remainder stays below clk_cnt, so it fits in 32 bits.
    logic [32:0] trial;
    logic [32:0] diff;
    logic        take;
    logic [31:0] rem_nxt;
    logic [63:0] quo_nxt;

    always_comb begin
        trial   = {rem_q, num_q[63]};
        diff    = trial - {1'b0, clk_cnt_q};
        take    = trial >= {1'b0, clk_cnt_q};
        rem_nxt = take ? diff[31:0] : trial[31:0];
        quo_nxt = {quo_q[62:0], take};
    end

    logic unused_meas_hi;
    assign unused_meas_hi = ^bus.meas_wr_data_i[95:64];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            sig_cnt_q  <= '0;
            clk_cnt_q  <= '0;
            num_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            iter_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            div0_q     <= 1'b0;
            busy_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            // Any pulse outside idle is discarded, including one coincident with the handshake.
            if (state_q != StIdle && bus.meas_wr_en_i && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.meas_wr_en_i) begin
                        sig_cnt_q <= bus.meas_wr_data_i[31:0];
                        clk_cnt_q <= bus.meas_wr_data_i[63:32];
                        busy_q    <= 1'b1;
                        if (bus.meas_wr_data_i[63:32] == 32'd0) begin
                            data_q  <= '1;
                            ovf_q   <= 1'b0;
                            div0_q  <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= StOut;
                        end else begin
                            state_q <= StMul;
                        end
                    end
                end
                StMul: begin
                    num_q   <= 64'(sig_cnt_q) * 64'(CLK_FREQ);
                    rem_q   <= '0;
                    quo_q   <= '0;
                    iter_q  <= '0;
                    state_q <= StDiv;
                end
                StDiv: begin
                    rem_q  <= rem_nxt;
                    quo_q  <= quo_nxt;
                    num_q  <= num_q << 1;
                    iter_q <= iter_q + 7'd1;
                    if (iter_q == 7'd63) begin
                        valid_q <= 1'b1;
                        div0_q  <= 1'b0;
                        state_q <= StOut;
                        if (quo_nxt[63:32] != 32'd0) begin
                            data_q <= '1;
                            ovf_q  <= 1'b1;
                        end else begin
                            data_q <= quo_nxt[31:0];
                            ovf_q  <= 1'b0;
                        end
                    end
                end
                StOut: begin
                    if (bus.freq_ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.freq_valid_o = valid_q;
    assign bus.freq_data_o  = data_q;
    assign bus.freq_ovf_o   = ovf_q;
    assign bus.freq_div0_o  = div0_q;
    assign bus.busy_o       = busy_q;
    assign bus.drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_freq_calc.sv
// tb_freq_calc: directed and randomized checks of freq_calc against a latency/arithmetic model.
module tb_freq_calc;
    localparam int unsigned CLK_FREQ = 100_000_000;

    logic clk = 1'b0;
    logic rst_n;
    freq_calc_if bus_if ();

    freq_calc #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {data, ovf, div0} straight from the arithmetic definition.
    function automatic logic [33:0] expect_of(input logic [95:0] d);
        logic [31:0] sig;
        logic [31:0] ck;
        logic [63:0] q;
        sig = d[31:0];
        ck  = d[63:32];
        if (ck == 32'd0) return {32'hFFFF_FFFF, 1'b0, 1'b1};
        q = (64'(sig) * 64'(CLK_FREQ)) / 64'(ck);
        if (q > 64'hFFFF_FFFF) return {32'hFFFF_FFFF, 1'b1, 1'b0};
        return {q[31:0], 2'b00};
    endfunction

    // Model: busy from accept to handshake, valid a fixed number of edges after accept.
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_cd    = 0;
    logic [15:0] m_drops = '0;
    logic [31:0] m_data  = '0;
    logic        m_ovf   = 1'b0;
    logic        m_div0  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cd    <= 0;
            m_drops <= '0;
        end else if (!m_busy) begin
            if (bus_if.meas_wr_en_i) begin
                m_busy <= 1'b1;
                {m_data, m_ovf, m_div0} <= expect_of(bus_if.meas_wr_data_i);
                if (bus_if.meas_wr_data_i[63:32] == 32'd0) m_valid <= 1'b1;
                else m_cd <= 65;
            end
        end else begin
            if (bus_if.meas_wr_en_i && m_drops != 16'hFFFF) m_drops <= m_drops + 16'd1;
            if (m_valid) begin
                if (bus_if.freq_ready_i) begin
                    m_valid <= 1'b0;
                    m_busy  <= 1'b0;
                end
            end else begin
                m_cd <= m_cd - 1;
                if (m_cd == 1) m_valid <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("valid", bus_if.freq_valid_o, m_valid);
            check("busy", bus_if.busy_o, m_busy);
            check("drop_cnt", bus_if.drop_cnt_o, m_drops);
            if (m_valid) begin
                check("data", bus_if.freq_data_o, m_data);
                check("ovf", bus_if.freq_ovf_o, m_ovf);
                check("div0", bus_if.freq_div0_o, m_div0);
            end
        end
    end

    task automatic pulse(input logic [31:0] sig, input logic [31:0] ck);
        @(negedge clk);
        bus_if.meas_wr_en_i   = 1'b1;
        bus_if.meas_wr_data_i = {$urandom(), ck, sig};
        @(negedge clk);
        bus_if.meas_wr_en_i   = 1'b0;
    endtask

    // Counts negedges from the sampling edge until valid (1 = visible right after that edge).
    task automatic wait_valid(output int n);
        n = 1;
        while (!bus_if.freq_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.freq_valid_o) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_valid", bus_if.freq_valid_o, 1'b0);
        check("rst_data", bus_if.freq_data_o, 32'd0);
        check("rst_ovf", bus_if.freq_ovf_o, 1'b0);
        check("rst_div0", bus_if.freq_div0_o, 1'b0);
        check("rst_busy", bus_if.busy_o, 1'b0);
        check("rst_drop", bus_if.drop_cnt_o, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals();
    endtask

    task automatic run_one(input logic [31:0] sig, input logic [31:0] ck, input logic [31:0] ed,
                           input logic eo, input logic ez, input int elat);
        int lat;
        pulse(sig, ck);
        wait_valid(lat);
        check("lit_latency", lat, elat);
        check("lit_data", bus_if.freq_data_o, ed);
        check("lit_ovf", bus_if.freq_ovf_o, eo);
        check("lit_div0", bus_if.freq_div0_o, ez);
        @(negedge clk);
        check("lit_idle_after", bus_if.busy_o, 1'b0);
    endtask

    function automatic logic [95:0] gen_meas();
        logic [31:0] sig;
        logic [31:0] ck;
        sig = $urandom();
        ck  = $urandom();
        case ($urandom_range(0, 5))
            0: ck = $urandom_range(1, 16);
            1: ck = 32'd0;
            2: sig = 32'd0;
            3: sig = 32'hFFFF_FFFF;
            4: begin
                sig = $urandom_range(0, 100_000);
                ck  = $urandom_range(1, 10_000_000);
            end
            default: ;
        endcase
        return {$urandom(), ck, sig};
    endfunction

    initial begin
        int lat;
        rst_n                 = 1'b0;
        bus_if.meas_wr_en_i   = 1'b0;
        bus_if.meas_wr_data_i = '0;
        bus_if.freq_ready_i   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n   = 1'b1;
        started = 1'b1;

        bus_if.freq_ready_i = 1'b1;
        run_one(32'd1000, 32'd100_000, 32'd1_000_000, 1'b0, 1'b0, 66);
        run_one(32'd1, 32'd3, 32'd33_333_333, 1'b0, 1'b0, 66);
        run_one(32'd0, 32'd5, 32'd0, 1'b0, 1'b0, 66);
        run_one(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 66);
        run_one(32'd42, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);

        // Backpressure with one drop in DIV and one in OUT, then a drop on the handshake edge.
        do_reset();
        bus_if.freq_ready_i = 1'b0;
        pulse(32'd1000, 32'd100_000);
        repeat (20) @(negedge clk);
        pulse(32'd3, 32'd4);
        wait_valid(lat);
        pulse(32'd9, 32'd9);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", bus_if.freq_valid_o, 1'b1);
            check("bp_data", bus_if.freq_data_o, 32'd1_000_000);
        end
        check("bp_drops", bus_if.drop_cnt_o, 16'd2);
        bus_if.freq_ready_i   = 1'b1;
        bus_if.meas_wr_en_i   = 1'b1;
        bus_if.meas_wr_data_i = {32'd0, 32'd10, 32'd10};
        @(negedge clk);
        bus_if.meas_wr_en_i   = 1'b0;
        check("hs_valid", bus_if.freq_valid_o, 1'b0);
        check("hs_busy", bus_if.busy_o, 1'b0);
        check("hs_drops", bus_if.drop_cnt_o, 16'd3);
        @(negedge clk);
        check("hs_no_start", bus_if.busy_o, 1'b0);

        // Drop counter saturation.
        do_reset();
        bus_if.freq_ready_i = 1'b0;
        pulse(32'd5, 32'd7);
        wait_valid(lat);
        check("sat_data", bus_if.freq_data_o, 32'd71_428_571);
        bus_if.meas_wr_en_i = 1'b1;
        repeat (65537) @(negedge clk);
        bus_if.meas_wr_en_i = 1'b0;
        @(negedge clk);
        check("sat_drops", bus_if.drop_cnt_o, 16'hFFFF);
        bus_if.freq_ready_i = 1'b1;
        @(negedge clk);
        check("sat_idle", bus_if.busy_o, 1'b0);

        // Reset sampled on the edge of DIV iteration 30.
        pulse(32'd1000, 32'd100_000);
        repeat (31) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals();
        repeat (80) @(negedge clk);
        check("rst_no_valid", bus_if.freq_valid_o, 1'b0);
        run_one(32'd7, 32'd1000, 32'd700_000, 1'b0, 1'b0, 66);

        // Randomized traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            bus_if.freq_ready_i = ($urandom_range(0, 2) != 0);
            if (!m_busy) bus_if.meas_wr_en_i = ($urandom_range(0, 3) == 0);
            else bus_if.meas_wr_en_i = ($urandom_range(0, 49) == 0);
            if (bus_if.meas_wr_en_i) bus_if.meas_wr_data_i = gen_meas();
        end
        @(negedge clk);
        bus_if.meas_wr_en_i = 1'b0;
        bus_if.freq_ready_i = 1'b1;
        repeat (100) @(negedge clk);
        check("drain_idle", bus_if.busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
